// File: rtl/avmm_row_fetch.sv
// rtl/avmm_row_fetch.sv - Avalon-MM row fetcher feeding the 8x8 MAC array byte stream
//
// Purpose:
//   Issues NUM_WORDS pipelined Avalon-MM word reads (word 0 = B vector, words 1..8 = A rows).
//   Returned words land in a small word buffer. Each buffered word is unpacked MSB-first into
//   a valid/ready byte stream, and every byte is tagged with its row and column.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   start                    1-cycle fetch request (ignored unless idle)
//   busy, done               fetch in progress / 1-cycle completion pulse
//   avm_address, avm_read    read request to the memory wrapper
//   avm_readdata             read response data
//   avm_readdatavalid        read response valid (in-order)
//   avm_waitrequest          slave stall
//   out_valid, out_ready     byte stream handshake
//   out_data                 byte value
//   out_row, out_col         source word index, byte index within the word
//   out_last                 final byte of the fetch
//   proto_err                sticky: response arrived with nothing in flight
//   checksum                 (FETCH_CHECKSUM_EN only) mod-2^16 sum of accepted bytes
//
// Configuration macro: FETCH_CHECKSUM_EN adds the checksum output.

module avmm_row_fetch #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 64,
  parameter int BYTE_W          = 8,
  parameter int NUM_WORDS       = 9,
  parameter int BASE_ADDR       = 0,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic [3:0]        out_row,
  output logic [2:0]        out_col,
  output logic              out_last,
`ifdef FETCH_CHECKSUM_EN
  output logic [15:0]       checksum,
`endif
  output logic              proto_err
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t            state, state_nx;
  logic [4:0]        issued;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [DATA_W-1:0] buf_mem [MAX_OUTSTANDING];
  logic [DATA_W-1:0] head_sh;
  logic [CNT_W:0]    in_use;
  logic [3:0]        row;
  logic [2:0]        col;

  logic accept, rdv_ok, hs, pop, credit, start_go;

  assign start_go = (state == IDLE) && start;
  assign accept   = avm_read && !avm_waitrequest;
  // A response is only legitimate if something is in flight, counting a zero-latency
  // response to a read accepted in this same cycle.
  assign rdv_ok   = avm_readdatavalid && ((outstanding != '0) || accept);
  assign hs       = out_valid && out_ready;
  assign pop      = hs && (col == 3'd7);

  // Credits cover both in-flight reads and words parked in the buffer, so every
  // response has a free slot. During a stall the sum can only fall, so avm_read holds.
  assign in_use   = {1'b0, outstanding} + {1'b0, count};
  assign credit   = in_use < (CNT_W+1)'(MAX_OUTSTANDING);

  assign avm_read    = (state == FETCH) && (issued < 5'(NUM_WORDS)) && credit;
  assign avm_address = avm_read ? (ADDR_W'(BASE_ADDR) + ADDR_W'(issued)) : '0;

  assign busy = (state == FETCH) || (state == DRAIN);
  assign done = (state == DONE);

  assign out_valid = (count != '0);
  assign out_row   = row;
  assign out_col   = col;
  assign out_last  = out_valid && (row == 4'(NUM_WORDS - 1)) && (col == 3'd7);

  // MSB-first unpack: shift the head word left by col bytes and take the top byte.
  always_comb begin
    head_sh  = buf_mem[rd_ptr] << (32'(col) * BYTE_W);
    out_data = out_valid ? head_sh[DATA_W-1 -: BYTE_W] : '0;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = FETCH;
      FETCH:   if (accept && (issued == 5'(NUM_WORDS - 1))) state_nx = DRAIN;
      DRAIN:   if (hs && out_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued      <= '0;
      outstanding <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      row         <= '0;
      col         <= '0;
      proto_err   <= 1'b0;
    end else begin
      if (start_go)    issued <= '0;
      else if (accept) issued <= issued + 5'd1;

      case ({accept, rdv_ok})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase

      case ({rdv_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (rdv_ok)
        wr_ptr <= (wr_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= (rd_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + 1'b1;

      // Tags return to 0 after the last byte so an idle block presents row/col 0.
      if (start_go) begin
        row <= '0;
        col <= '0;
      end else if (hs) begin
        if (col == 3'd7) begin
          col <= '0;
          row <= out_last ? 4'd0 : row + 4'd1;
        end else begin
          col <= col + 3'd1;
        end
      end

      if (avm_readdatavalid && (outstanding == '0) && !accept)
        proto_err <= 1'b1;
    end
  end

  // Data storage needs no reset: out_valid gates every read of it.
  always_ff @(posedge clk) begin
    if (rdv_ok) buf_mem[wr_ptr] <= avm_readdata;
  end

`ifdef FETCH_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        checksum <= '0;
    else if (start_go) checksum <= '0;
    else if (hs)       checksum <= checksum + 16'(out_data);
  end
`endif

endmodule

// File: tb/tb_avmm_row_fetch.sv
// tb/tb_avmm_row_fetch.sv - self-checking bench for avmm_row_fetch
module tb_avmm_row_fetch;

  logic        clk = 1'b0;
  logic        rst_n, start, busy, done;
  logic [31:0] avm_address;
  logic        avm_read;
  logic [63:0] avm_readdata;
  logic        avm_readdatavalid, avm_waitrequest;
  logic        out_valid, out_ready, out_last, proto_err;
  logic [7:0]  out_data;
  logic [3:0]  out_row;
  logic [2:0]  out_col;
`ifdef FETCH_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  always #5 clk = ~clk;

  avmm_row_fetch dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last),
`ifdef FETCH_CHECKSUM_EN
    .checksum(checksum),
`endif
    .proto_err(proto_err)
  );

  typedef struct {logic [7:0] d; logic [3:0] r; logic [2:0] c; logic l;} ent_t;

  int          checks = 0, errors = 0;
  logic [63:0] mem [16];
  ent_t        exp_q[$];
  int          lat = 1, nstall = 0, ready_mode = 0, cyc = 0, start_cyc = 0;
  logic        inject = 1'b0;
  int          acc_total = 0, hs_count = 0;
  logic [31:0] acc_addrs[$];
  logic [7:0]  got_data[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Memory slave + per-cycle input driver.
  initial begin
    logic [3:0] pq_addr[$];
    int         pq_due[$];
    logic       acc;
    logic [3:0] acc_a;
    int         stall_ctr;
    stall_ctr = 0;
    avm_readdatavalid = 1'b0; avm_readdata = '0; avm_waitrequest = 1'b0; out_ready = 1'b1;
    forever begin
      @(negedge clk);
      acc   = rst_n && avm_read && !avm_waitrequest;
      acc_a = avm_address[3:0];
      @(posedge clk); #1;
      cyc++;
      if (!rst_n) begin
        pq_addr.delete(); pq_due.delete(); stall_ctr = 0; acc = 1'b0;
      end
      if (acc) begin
        pq_addr.push_back(acc_a); pq_due.push_back(cyc + lat - 1); stall_ctr = 0;
      end
      if (pq_due.size() > 0 && pq_due[0] <= cyc) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = mem[pq_addr[0]];
        void'(pq_addr.pop_front()); void'(pq_due.pop_front());
      end else begin
        avm_readdatavalid = inject;
        avm_readdata      = 64'hdead_beef_dead_beef;
      end
      if (avm_read && stall_ctr < nstall) begin
        avm_waitrequest = 1'b1; stall_ctr++;
      end else begin
        avm_waitrequest = 1'b0;
      end
      case (ready_mode)
        1:       out_ready = (cyc % 2) == 0;
        2:       out_ready = (cyc - start_cyc) >= 50;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Compare process: checks DUT outputs against the behavioural model every cycle.
  initial begin
    int          infl, bufd;
    logic        prev_stall, prev_hold, prev_last, exp_perr, acc, rdv_ok, hs;
    logic [31:0] prev_addr;
    ent_t        prev_b, e;
    infl = 0; bufd = 0; prev_stall = 0; prev_hold = 0; prev_last = 0; exp_perr = 0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        infl = 0; bufd = 0; prev_stall = 0; prev_hold = 0; prev_last = 0; exp_perr = 0;
      end else begin
        chk("done_pulse", done, prev_last);
        chk("proto_err", proto_err, exp_perr);
        checks++;
        if (infl + bufd > 4) begin
          errors++;
          $display("FAIL credit: in_use %0d exceeds required max 4", infl + bufd);
        end
        if (prev_stall) begin
          chk("stall_read", avm_read, 1);
          chk("stall_addr", avm_address, prev_addr);
        end
        if (prev_hold) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", out_data, prev_b.d);
          chk("hold_row", out_row, prev_b.r);
          chk("hold_col", out_col, prev_b.c);
        end
        hs = out_valid && out_ready;
        if (hs) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_byte", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("byte_data", out_data, e.d);
            chk("byte_row", out_row, e.r);
            chk("byte_col", out_col, e.c);
            chk("byte_last", out_last, e.l);
          end
          got_data.push_back(out_data);
          hs_count++;
        end
        acc    = avm_read && !avm_waitrequest;
        rdv_ok = avm_readdatavalid && (infl > 0 || acc);
        if (avm_readdatavalid && infl == 0 && !acc) exp_perr = 1'b1;
        infl = infl + int'(acc) - int'(rdv_ok);
        bufd = bufd + int'(rdv_ok) - int'(hs && out_col == 3'd7);
        if (acc) begin
          acc_total++;
          acc_addrs.push_back(avm_address);
        end
        prev_stall = avm_read && avm_waitrequest;
        prev_addr  = avm_address;
        prev_hold  = out_valid && !out_ready;
        prev_b.d = out_data; prev_b.r = out_row; prev_b.c = out_col; prev_b.l = out_last;
        prev_last  = hs && out_last;
      end
    end
  end

  task automatic load_pattern();
    for (int k = 0; k < 16; k++) mem[k] = {8{8'(k + 1)}};
  endtask

  task automatic build_expect();
    logic [63:0] w;
    ent_t        e;
    exp_q.delete();
    for (int r = 0; r < 9; r++) begin
      w = mem[r];
      for (int c = 0; c < 8; c++) begin
        e.d = w[63 - 8*c -: 8]; e.r = 4'(r); e.c = 3'(c); e.l = (r == 8 && c == 7);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic chk_zero();
    chk("rst_busy", busy, 0);        chk("rst_done", done, 0);
    chk("rst_read", avm_read, 0);    chk("rst_addr", avm_address, 0);
    chk("rst_valid", out_valid, 0);  chk("rst_data", out_data, 0);
    chk("rst_row", out_row, 0);      chk("rst_col", out_col, 0);
    chk("rst_last", out_last, 0);    chk("rst_perr", proto_err, 0);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1; start_cyc = cyc;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_fetch(input bit poke, input int exp_sum);
    bit seen;
    seen = 0;
    build_expect();
    got_data.delete(); hs_count = 0;
    pulse_start();
    @(negedge clk) chk("busy_after_start", busy, 1);
    if (poke) pulse_start();
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("done_seen", seen, 1);
`ifdef FETCH_CHECKSUM_EN
    chk("checksum", checksum, 16'(exp_sum));
`else
    if (exp_sum < 0) $display("exp_sum unused");
`endif
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("bytes_left", exp_q.size(), 0);
    chk("byte_count", hs_count, 72);
  endtask

  initial begin
    bit reached;
    int base;
    rst_n = 1'b0; start = 1'b0;
    load_pattern();
    repeat (3) @(posedge clk);
    @(negedge clk) chk_zero();
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 1: basic fetch, with an ignored start pulse mid-fetch
    run_fetch(1, 360);
    chk("t1_first", got_data[0], 8'h01);
    chk("t1_b8", got_data[8], 8'h02);
    chk("t1_last", got_data[71], 8'h09);

    // 2: waitrequest 3 cycles per read
    nstall = 3; acc_addrs.delete();
    run_fetch(0, 360);
    chk("t2_reads", acc_addrs.size(), 9);
    for (int i = 0; i < 9 && i < acc_addrs.size(); i++) chk("t2_addr", acc_addrs[i], i);
    nstall = 0;

    // 3: long latency, consumer stalled for 50 cycles
    lat = 10; ready_mode = 2;
    run_fetch(0, 360);
    chk("t3_first", got_data[0], 8'h01);
    chk("t3_last", got_data[71], 8'h09);
    lat = 1; ready_mode = 0;

    // 4: toggling ready, distinct bytes in word 0
    mem[0] = 64'h0102030405060708; ready_mode = 1;
    run_fetch(0, 388);
    for (int i = 0; i < 8; i++) chk("t4_row0", got_data[i], 8'(i + 1));
    load_pattern(); ready_mode = 0;

    // 5: stray readdatavalid while idle
    @(negedge clk) inject = 1'b1;
    @(negedge clk) inject = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_perr_set", proto_err, 1);
    run_fetch(0, 360);
    chk("t5_perr_sticky", proto_err, 1);

    // 6: reset at the fifth accepted read, then restart
    build_expect();
    base = acc_total; reached = 0;
    pulse_start();
    for (int i = 0; i < 500 && !reached; i++) begin
      @(negedge clk);
      if (acc_total >= base + 5) reached = 1;
    end
    chk("t6_reads_reached", reached, 1);
    @(posedge clk); #2 rst_n = 1'b0;
    @(negedge clk) chk_zero();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run_fetch(0, 360);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
